// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline run-control block: FSM encodings,
// default pipeline geometry and inter-stage latch indices.
package pipeline_pkg;

    localparam int unsigned NUM_STAGES_DEF   = 5;
    localparam int unsigned BRANCH_STAGE_DEF = 3;
    localparam int unsigned STATE_W          = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam int unsigned L_IF_ID  = 0;
    localparam int unsigned L_ID_EX  = 1;
    localparam int unsigned L_EX_MEM = 2;
    localparam int unsigned L_MEM_WB = 3;

    // Pipeline advances (PC/latches may move, cycle counter ticks)
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter with a terminal flag raised when the count is at or
// below one; shared by the step budget and the post-HALT drain.
module step_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign terminal = (count <= W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Run-control and pipeline sequencing: run/step/halt modes, load-use stalls,
// branch flushes and the drain of in-flight instructions after HALT.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = NUM_STAGES_DEF,
    parameter int unsigned BRANCH_STAGE = BRANCH_STAGE_DEF,
    parameter int unsigned STEP_W       = 16,
    parameter int unsigned CYC_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_run,
    input  logic                  i_halt,
    input  logic                  i_step,
    input  logic [STEP_W-1:0]     i_step_count,
    input  logic                  i_load_hazard,
    input  logic                  i_branch_taken,
    input  logic                  i_halt_detect,
    output logic                  o_pc_enable,
    output logic [NUM_STAGES-2:0] o_latch_enable,
    output logic [NUM_STAGES-2:0] o_latch_flush,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_halted,
    output logic [CYC_W-1:0]      o_cycle_count
);

    localparam int unsigned LW = NUM_STAGES - 1;
    localparam logic [LW-1:0] WRONG_PATH_MASK = LW'((64'd1 << BRANCH_STAGE) - 64'd1);
    localparam logic [STEP_W-1:0] DRAIN_LEN = STEP_W'(NUM_STAGES - 2);

    state_e              state, state_nx;
    logic                active;
    logic                halt_req;
    logic                step_load, step_dec, step_term;
    logic                drain_load, drain_dec, drain_term;
    logic [STEP_W-1:0]   step_value;
    logic [CYC_W-1:0]    cycle_count;

    assign active     = is_active(state);
    // A HALT seen alongside a taken branch is on the wrong path
    assign halt_req   = i_halt_detect && !i_branch_taken;
    assign step_value = (i_step_count == '0) ? STEP_W'(1) : i_step_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        step_load      = 1'b0;
        step_dec       = 1'b0;
        drain_load     = 1'b0;
        drain_dec      = 1'b0;
        o_pc_enable    = 1'b0;
        o_latch_enable = '0;
        o_latch_flush  = '0;

        case (state)
            ST_IDLE: begin
                if (i_halt) begin
                    state_nx = ST_IDLE;
                end else if (i_run) begin
                    state_nx = ST_RUN;
                end else if (i_step) begin
                    state_nx  = ST_STEP;
                    step_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_nx = ST_IDLE;
                end else if (halt_req) begin
                    state_nx   = ST_DRAIN;
                    drain_load = 1'b1;
                end
            end
            ST_STEP: begin
                step_dec = 1'b1;
                if (i_halt) begin
                    state_nx = ST_IDLE;
                end else if (halt_req) begin
                    state_nx   = ST_DRAIN;
                    drain_load = 1'b1;
                end else if (step_term) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                drain_dec = 1'b1;
                if (drain_term) begin
                    state_nx = ST_HALTED;
                end
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase

        // Strobe decode: drain > branch > load-use hazard > normal advance
        if (active) begin
            o_pc_enable    = 1'b1;
            o_latch_enable = '1;
            if (state == ST_DRAIN) begin
                o_pc_enable            = 1'b0;
                o_latch_flush[L_IF_ID] = 1'b1;
                if (i_branch_taken) begin
                    o_latch_flush = o_latch_flush | WRONG_PATH_MASK;
                end
            end else begin
                if (i_branch_taken) begin
                    o_latch_flush = WRONG_PATH_MASK;
                end else if (i_load_hazard) begin
                    o_pc_enable             = 1'b0;
                    o_latch_enable[L_IF_ID] = 1'b0;
                    o_latch_flush[L_ID_EX]  = 1'b1;
                end
                if (halt_req) begin
                    o_pc_enable = 1'b0;
                end
            end
        end
    end

    step_counter #(.W(STEP_W)) u_step_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (step_load),
        .load_value (step_value),
        .dec        (step_dec),
        .terminal   (step_term)
    );

    step_counter #(.W(STEP_W)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (drain_load),
        .load_value (DRAIN_LEN),
        .dec        (drain_dec),
        .terminal   (drain_term)
    );

    // Saturating count of active cycles, stalls included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (active && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYC_W'(1);
        end
    end

    assign o_state       = state;
    assign o_halted      = (state == ST_HALTED);
    assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a 5-stage and a 7-stage instance share
// stimulus; a behavioural model queues expected strobes checked at negedge.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic        pc;
        logic [7:0]  le;
        logic [7:0]  fl;
        logic [2:0]  st;
        logic        halted;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run, i_halt, i_step, i_load_hazard, i_branch_taken, i_halt_detect;
    logic [15:0] i_step_count;

    logic        pc0, h0, pc1, h1;
    logic [3:0]  le0, fl0;
    logic [5:0]  le1, fl1;
    logic [2:0]  st0, st1;
    logic [31:0] cyc0, cyc1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];

    int     ns[2] = '{5, 7};
    int     bs[2] = '{3, 4};
    int     m_mode[2];
    int     m_rem[2];
    int     m_drain[2];
    longint m_cyc[2];

    always #5 clk = ~clk;

    pipeline_ctrl #(.NUM_STAGES(5), .BRANCH_STAGE(3)) dut5 (
        .clk(clk), .rst(rst), .i_run(i_run), .i_halt(i_halt), .i_step(i_step),
        .i_step_count(i_step_count), .i_load_hazard(i_load_hazard),
        .i_branch_taken(i_branch_taken), .i_halt_detect(i_halt_detect),
        .o_pc_enable(pc0), .o_latch_enable(le0), .o_latch_flush(fl0),
        .o_state(st0), .o_halted(h0), .o_cycle_count(cyc0)
    );

    pipeline_ctrl #(.NUM_STAGES(7), .BRANCH_STAGE(4)) dut7 (
        .clk(clk), .rst(rst), .i_run(i_run), .i_halt(i_halt), .i_step(i_step),
        .i_step_count(i_step_count), .i_load_hazard(i_load_hazard),
        .i_branch_taken(i_branch_taken), .i_halt_detect(i_halt_detect),
        .o_pc_enable(pc1), .o_latch_enable(le1), .o_latch_flush(fl1),
        .o_state(st1), .o_halted(h1), .o_cycle_count(cyc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mode numbers: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    function automatic exp_t model_out(input int k);
        exp_t e;
        logic [7:0] ones;
        logic [7:0] wp;
        ones     = 8'((1 << (ns[k] - 1)) - 1);
        wp       = 8'((1 << bs[k]) - 1);
        e        = '0;
        e.st     = 3'(m_mode[k]);
        e.halted = (m_mode[k] == 4);
        e.cyc    = 32'(m_cyc[k]);
        if (m_mode[k] >= 1 && m_mode[k] <= 3) begin
            e.pc = 1'b1;
            e.le = ones;
            if (m_mode[k] == 3) begin
                e.pc = 1'b0;
                e.fl = 8'd1 | (i_branch_taken ? wp : 8'd0);
            end else begin
                if (i_branch_taken) begin
                    e.fl = wp;
                end else if (i_load_hazard) begin
                    e.pc = 1'b0;
                    e.le = ones & ~8'd1;
                    e.fl = 8'd2;
                end
                if (i_halt_detect && !i_branch_taken) e.pc = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic model_advance(input int k);
        bit was_active;
        bit halt_ok;
        was_active = (m_mode[k] >= 1 && m_mode[k] <= 3);
        halt_ok    = i_halt_detect && !i_branch_taken;
        case (m_mode[k])
            0: begin
                if (i_halt) m_mode[k] = 0;
                else if (i_run) m_mode[k] = 1;
                else if (i_step) begin
                    m_mode[k] = 2;
                    m_rem[k]  = (i_step_count == 16'd0) ? 1 : int'(i_step_count);
                end
            end
            1: begin
                if (i_halt) m_mode[k] = 0;
                else if (halt_ok) begin m_mode[k] = 3; m_drain[k] = ns[k] - 2; end
            end
            2: begin
                if (i_halt) m_mode[k] = 0;
                else if (halt_ok) begin m_mode[k] = 3; m_drain[k] = ns[k] - 2; end
                else if (m_rem[k] == 1) m_mode[k] = 0;
                else m_rem[k]--;
            end
            3: begin
                if (m_drain[k] == 1) m_mode[k] = 4;
                else m_drain[k]--;
            end
            default: m_mode[k] = 4;
        endcase
        if (was_active && m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_rem[k] = 0; m_drain[k] = 0; m_cyc[k] = 0;
        end
    endtask

    task automatic drive_idle();
        i_run = 0; i_halt = 0; i_step = 0; i_step_count = '0;
        i_load_hazard = 0; i_branch_taken = 0; i_halt_detect = 0;
    endtask

    // One clock of stimulus: drive inputs, queue expectations, advance the model
    task automatic cyc(input bit r, input bit h, input bit s, input int cnt,
                       input bit z, input bit b, input bit d);
        @(posedge clk);
        #1;
        i_run = r; i_halt = h; i_step = s; i_step_count = 16'(cnt);
        i_load_hazard = z; i_branch_taken = b; i_halt_detect = d;
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        model_advance(0);
        model_advance(1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d5_pc"},  32'(pc0), 32'd0);
        check({tag, "_d5_le"},  32'(le0), 32'd0);
        check({tag, "_d5_fl"},  32'(fl0), 32'd0);
        check({tag, "_d5_st"},  32'(st0), 32'd0);
        check({tag, "_d5_hlt"}, 32'(h0),  32'd0);
        check({tag, "_d5_cyc"}, cyc0,     32'd0);
        check({tag, "_d7_pc"},  32'(pc1), 32'd0);
        check({tag, "_d7_le"},  32'(le1), 32'd0);
        check({tag, "_d7_fl"},  32'(fl1), 32'd0);
        check({tag, "_d7_st"},  32'(st1), 32'd0);
        check({tag, "_d7_hlt"}, 32'(h1),  32'd0);
        check({tag, "_d7_cyc"}, cyc1,     32'd0);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock
    task automatic async_reset();
        @(posedge clk);
        #2;
        check("pre_rst_d5_state", 32'(st0), 32'(m_mode[0]));
        check("pre_rst_d7_state", 32'(st1), 32'(m_mode[1]));
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        drive_idle();
        model_reset();
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("d5_pc",  32'(pc0), 32'(e.pc));
            check("d5_le",  32'(le0), 32'(e.le[3:0]));
            check("d5_fl",  32'(fl0), 32'(e.fl[3:0]));
            check("d5_st",  32'(st0), 32'(e.st));
            check("d5_hlt", 32'(h0),  32'(e.halted));
            check("d5_cyc", cyc0,     e.cyc);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("d7_pc",  32'(pc1), 32'(e.pc));
            check("d7_le",  32'(le1), 32'(e.le[5:0]));
            check("d7_fl",  32'(fl1), 32'(e.fl[5:0]));
            check("d7_st",  32'(st1), 32'(e.st));
            check("d7_hlt", 32'(h1),  32'(e.halted));
            check("d7_cyc", cyc1,     e.cyc);
        end
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        #2;
        check_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Free run for 10 cycles, then halt back to idle
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Step of 3, then step with count 0 (treated as 1)
        cyc(0, 0, 1, 3, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);

        // Load-use stall, then branch overriding hazard and a wrong-path HALT
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 1);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // HALT opcode: drain ignoring halt/step/hazard, then sticky halted
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 1, 1, 2, 1, 0, 0);
        repeat (6) cyc(1, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a drain
        async_reset();
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        async_reset();

        // Randomised traffic with periodic resets to escape HALTED
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 149) begin
                async_reset();
            end else begin
                cyc(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 5) == 0,
                    int'($urandom_range(0, 4)), ($urandom % 4) == 0,
                    ($urandom % 5) == 0, ($urandom % 40) == 0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central run-control and pipeline-sequencing block for the MIPS core, parametrised in stage count.
- Generates the PC enable plus per-latch enable and flush (bubble) strobes for all NUM_STAGES-1 inter-stage latches.
- Handles run/step/halt modes under debug control.
- Applies load-use stalls and branch flushes.
- Drains in-flight instructions after a HALT opcode.
- Sits beside the hazard unit; drives IF, the stage latches and the debug interface.

Parameters:
NUM_STAGES, 5, pipeline depth; latch k (0..NUM_STAGES-2) sits between stage k and stage k+1 (IF=0).
BRANCH_STAGE, 3, stage index where branches resolve; wrong-path latches are 0..BRANCH_STAGE-1.
STEP_W, 16, width of step counter and step request.
CYC_W, 32, width of active-cycle counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_run  in  1  level; start free-running from IDLE
i_halt  in  1  level; pause (no drain) back to IDLE
i_step  in  1  pulse; start stepping from IDLE
i_step_count  in  STEP_W  cycles to execute per step request; 0 treated as 1
i_load_hazard  in  1  load-use hazard from hazard detection
i_branch_taken  in  1  branch/jump resolved taken at BRANCH_STAGE
i_halt_detect  in  1  HALT opcode decoded in ID
o_pc_enable  out  1  PC register update enable
o_latch_enable  out  NUM_STAGES-1  per-latch load enable
o_latch_flush  out  NUM_STAGES-1  per-latch synchronous clear (bubble)
o_state  out  3  encoded FSM state
o_halted  out  1  high in HALTED
o_cycle_count  out  CYC_W  active cycles since reset, saturating

Behaviour:
- Reset: asynchronous, active-high. State IDLE, step counter 0, drain counter 0, o_cycle_count 0, o_halted 0.
- All enables and flushes are combinational from registered state and inputs. All are 0 in IDLE and HALTED.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE transitions:
  - i_halt has highest priority: stay IDLE.
  - else i_run -> RUN.
  - else i_step -> STEP, load remaining = max(i_step_count, 1).
- RUN: i_halt -> IDLE next cycle. The current cycle is still active.
- STEP: each active cycle decrements remaining; when remaining == 1 -> IDLE. i_halt -> IDLE and abandons remaining.
- "active" means state is RUN, STEP or DRAIN.
- Normal active cycle: o_pc_enable = 1, all o_latch_enable = 1, all flushes 0.
- Load-use hazard (active, not DRAIN):
  - o_pc_enable = 0 and o_latch_enable[0] = 0 (hold IF/ID).
  - o_latch_flush[1] = 1 (bubble into EX).
  - Other latches advance.
- Branch taken (active): o_latch_flush[k] = 1 for k < BRANCH_STAGE, o_pc_enable = 1. Branch overrides hazard; enables follow the normal case.
- i_halt_detect in RUN/STEP with no branch taken:
  - Next state DRAIN; drain counter = NUM_STAGES-2.
  - From the detect cycle on, the PC is frozen.
- i_halt_detect together with i_branch_taken is ignored (wrong path).
- DRAIN:
  - o_pc_enable = 0, o_latch_flush[0] = 1, all latches enabled.
  - Counter decrements each cycle; at 1 -> HALTED.
  - i_halt, i_step and hazards are ignored in DRAIN.
- HALTED: sticky until rst; o_halted = 1.
- o_cycle_count increments every active cycle, including stalled ones, and saturates at all-ones.
- Reset mid-operation returns to IDLE immediately; no partial drain.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encodings ST_IDLE..ST_HALTED;
  - NUM_STAGES and BRANCH_STAGE defaults;
  - latch index names L_IF_ID=0, L_ID_EX=1, L_EX_MEM=2, L_MEM_WB=3.
- One sub-module, step_counter: loadable down-counter with terminal flag, STEP_W wide. It is reused for the drain count.
- FSM and strobe decode stay in pipeline_ctrl.

Test Plan:
1. Reset, then i_run=1 for 10 cycles -> o_state=1; o_pc_enable=1 and o_latch_enable=4'b1111 every cycle; o_cycle_count=10.
2. i_step with i_step_count=3 from IDLE -> exactly 3 active cycles, then o_state=0. A second step with count 0 -> exactly 1 active cycle.
3. RUN with i_load_hazard for 1 cycle -> that cycle o_pc_enable=0, o_latch_enable=4'b1110, o_latch_flush=4'b0010; the next cycle is normal.
4. RUN with i_branch_taken and i_load_hazard in the same cycle -> o_latch_flush=4'b0111, o_pc_enable=1. i_halt_detect in that cycle must not enter DRAIN.
5. RUN, pulse i_halt_detect -> DRAIN for 3 cycles with o_pc_enable=0 and o_latch_flush=4'b0001, then o_halted=1. It stays halted despite i_run until rst.
6. Assert rst asynchronously mid-DRAIN -> outputs are zero and state is IDLE before the next clk edge. Re-run with NUM_STAGES=7, BRANCH_STAGE=4 -> drain lasts 5 cycles and the branch flush is 6'b001111.
